// File: rtl/led_mode_ctrl.sv
// LED mode controller: debounced push-button cycles BLINK/RUN/ALL_ON/OFF,
// a free-running tick counter paces the LED animation.
module led_mode_ctrl #(
  parameter int CNT_MAX = 49_999_999,
  parameter int DEB_MAX = 999_999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [3:0] led,
  output logic [1:0] mode
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int DW = (DEB_MAX > 0) ? $clog2(DEB_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_MAX);

  typedef enum logic [1:0] {
    BLINK  = 2'd0,
    RUN    = 2'd1,
    ALL_ON = 2'd2,
    OFF    = 2'd3
  } mode_t;

  logic          key_p0;
  logic          key_p1;
  logic          stable;
  logic          stable_p1;
  logic [DW-1:0] deb_cnt;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          key_press;
  mode_t         state;

  // stage p0/p1: two-flop synchronizer, idles high (button released)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= key_in;
      key_p1 <= key_p0;
    end
  end

  // debounce: the level must differ for DEB_MAX+1 consecutive cycles to be accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable    <= 1'b1;
      stable_p1 <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      stable_p1 <= stable;
      if (key_p1 == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        stable  <= key_p1;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign key_press = stable_p1 & ~stable;
  assign tick      = (tick_cnt == CNT_LAST);

  // a key press restarts the animation period so the new mode gets a full tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (key_press || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BLINK;
      led   <= 4'b0000;
    end else if (key_press) begin
      case (state)
        BLINK:   begin state <= RUN;    led <= 4'b0001; end
        RUN:     begin state <= ALL_ON; led <= 4'b1111; end
        ALL_ON:  begin state <= OFF;    led <= 4'b0000; end
        default: begin state <= BLINK;  led <= 4'b0000; end
      endcase
    end else if (tick) begin
      case (state)
        BLINK:   led <= ~led;
        RUN:     led <= {led[2:0], led[3]};
        default: led <= led;
      endcase
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with CNT_MAX=9, DEB_MAX=3.
module tb_led_mode_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key_in;
  logic [3:0] led;
  logic [1:0] mode;
  int         passed;
  int         total;

  led_mode_ctrl #(.CNT_MAX(9), .DEB_MAX(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .led    (led),
    .mode   (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // advance n rising edges, returning 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one reset edge; on return rst_n is high and this is edge E0
  task automatic reset_dut();
    rst_n  = 1'b0;
    key_in = 1'b1;
    step(1);
    rst_n  = 1'b1;
  endtask

  // press starting now: mode changes on the 7th edge; returns 13 edges later, key released and settled
  task automatic press();
    key_in = 1'b0;
    step(7);
    key_in = 1'b1;
    step(6);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    key_in = 1'b1;
    step(3);
    total++; if (led !== 4'b0000) $display("FAIL reset_led got=%b want=0000", led); else passed++;
    total++; if (mode !== 2'd0) $display("FAIL reset_mode got=%0d want=0", mode); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_blink();
    reset_dut();
    step(9);
    total++; if (led !== 4'b0000) $display("FAIL blink_e9 got=%b want=0000", led); else passed++;
    step(1);
    total++; if (led !== 4'b1111) $display("FAIL blink_e10 got=%b want=1111", led); else passed++;
    step(10);
    total++; if (led !== 4'b0000) $display("FAIL blink_e20 got=%b want=0000", led); else passed++;
    step(10);
    total++; if (led !== 4'b1111) $display("FAIL blink_e30 got=%b want=1111", led); else passed++;
    step(10);
    total++; if (led !== 4'b0000) $display("FAIL blink_e40 got=%b want=0000", led); else passed++;
    total++; if (mode !== 2'd0) $display("FAIL blink_mode got=%0d want=0", mode); else passed++;
  endtask

  task automatic test_single_press();
    reset_dut();
    key_in = 1'b0;
    step(6);
    total++; if (mode !== 2'd0) $display("FAIL press_e6_mode got=%0d want=0", mode); else passed++;
    step(1);
    total++; if (mode !== 2'd1) $display("FAIL press_e7_mode got=%0d want=1", mode); else passed++;
    total++; if (led !== 4'b0001) $display("FAIL press_e7_led got=%b want=0001", led); else passed++;
    step(9);
    total++; if (led !== 4'b0001) $display("FAIL run_e16 got=%b want=0001", led); else passed++;
    step(1);
    total++; if (led !== 4'b0010) $display("FAIL run_e17 got=%b want=0010", led); else passed++;
    step(3);
    key_in = 1'b1;
    step(7);
    total++; if (led !== 4'b0100) $display("FAIL run_e27 got=%b want=0100", led); else passed++;
    step(10);
    total++; if (led !== 4'b1000) $display("FAIL run_e37 got=%b want=1000", led); else passed++;
    step(10);
    total++; if (led !== 4'b0001) $display("FAIL run_e47 got=%b want=0001", led); else passed++;
    total++; if (mode !== 2'd1) $display("FAIL run_release_mode got=%0d want=1", mode); else passed++;
  endtask

  task automatic test_min_press();
    reset_dut();
    key_in = 1'b0;
    step(4);
    key_in = 1'b1;
    step(2);
    total++; if (mode !== 2'd0) $display("FAIL minpress_e6 got=%0d want=0", mode); else passed++;
    step(1);
    total++; if (mode !== 2'd1) $display("FAIL minpress_e7 got=%0d want=1", mode); else passed++;
    step(10);
    total++; if (mode !== 2'd1) $display("FAIL minpress_e17 got=%0d want=1", mode); else passed++;
  endtask

  task automatic test_glitch();
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      key_in = 1'b0;
      step(3);
      key_in = 1'b1;
      step(3);
    end
    total++; if (led !== 4'b1111) $display("FAIL glitch_e36_led got=%b want=1111", led); else passed++;
    total++; if (mode !== 2'd0) $display("FAIL glitch_e36_mode got=%0d want=0", mode); else passed++;
    step(4);
    total++; if (led !== 4'b0000) $display("FAIL glitch_e40_led got=%b want=0000", led); else passed++;
    total++; if (mode !== 2'd0) $display("FAIL glitch_e40_mode got=%0d want=0", mode); else passed++;
  endtask

  task automatic test_mode_cycle();
    reset_dut();
    press();
    total++; if (mode !== 2'd1) $display("FAIL cycle1_mode got=%0d want=1", mode); else passed++;
    total++; if (led !== 4'b0001) $display("FAIL cycle1_led got=%b want=0001", led); else passed++;
    press();
    total++; if (mode !== 2'd2) $display("FAIL cycle2_mode got=%0d want=2", mode); else passed++;
    total++; if (led !== 4'b1111) $display("FAIL cycle2_led got=%b want=1111", led); else passed++;
    step(10);
    total++; if (led !== 4'b1111) $display("FAIL allon_hold got=%b want=1111", led); else passed++;
    press();
    total++; if (mode !== 2'd3) $display("FAIL cycle3_mode got=%0d want=3", mode); else passed++;
    total++; if (led !== 4'b0000) $display("FAIL cycle3_led got=%b want=0000", led); else passed++;
    step(10);
    total++; if (led !== 4'b0000) $display("FAIL off_hold got=%b want=0000", led); else passed++;
    press();
    total++; if (mode !== 2'd0) $display("FAIL cycle4_mode got=%0d want=0", mode); else passed++;
    total++; if (led !== 4'b0000) $display("FAIL cycle4_led got=%b want=0000", led); else passed++;
    step(4);
    total++; if (led !== 4'b1111) $display("FAIL blink_resume got=%b want=1111", led); else passed++;
  endtask

  task automatic test_collision();
    reset_dut();
    step(13);
    key_in = 1'b0;
    step(6);
    total++; if (led !== 4'b1111) $display("FAIL coll_e19_led got=%b want=1111", led); else passed++;
    total++; if (mode !== 2'd0) $display("FAIL coll_e19_mode got=%0d want=0", mode); else passed++;
    step(1);
    key_in = 1'b1;
    total++; if (mode !== 2'd1) $display("FAIL coll_e20_mode got=%0d want=1", mode); else passed++;
    total++; if (led !== 4'b0001) $display("FAIL coll_e20_led got=%b want=0001", led); else passed++;
    step(9);
    total++; if (led !== 4'b0001) $display("FAIL coll_e29_led got=%b want=0001", led); else passed++;
    step(1);
    total++; if (led !== 4'b0010) $display("FAIL coll_e30_led got=%b want=0010", led); else passed++;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    press();
    key_in = 1'b0;
    step(4);
    total++; if (mode !== 2'd1) $display("FAIL mid_pre_mode got=%0d want=1", mode); else passed++;
    rst_n  = 1'b0;
    key_in = 1'b1;
    step(1);
    rst_n = 1'b1;
    total++; if (mode !== 2'd0) $display("FAIL mid_rst_mode got=%0d want=0", mode); else passed++;
    total++; if (led !== 4'b0000) $display("FAIL mid_rst_led got=%b want=0000", led); else passed++;
    step(9);
    total++; if (led !== 4'b0000) $display("FAIL mid_e9_led got=%b want=0000", led); else passed++;
    step(1);
    total++; if (led !== 4'b1111) $display("FAIL mid_e10_led got=%b want=1111", led); else passed++;
    step(10);
    total++; if (mode !== 2'd0) $display("FAIL mid_e20_mode got=%0d want=0", mode); else passed++;
    total++; if (led !== 4'b0000) $display("FAIL mid_e20_led got=%b want=0000", led); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    key_in = 1'b1;
    test_reset();
    test_blink();
    test_single_press();
    test_min_press();
    test_glitch();
    test_mode_cycle();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
